note_lane_pingpong_buf: RTL and testbench

Parametrised double-buffered store for note-lane vertical positions in the rhythm-game video path. A position producer fills the back bank with one frame of per-lane, per-slot y values. The VGA-side renderer reads the front bank. Banks swap only on a frame tick after the producer has committed a complete frame, so the display never shows a half-written frame. Compared with the single-lane predecessor, this block adds configurable lanes, depth and width, a clear sweep, commit-gated swaps and a dropped-frame counter.

---
 rtl/note_lane_pingpong_buf_pkg.sv | 20 ++
 rtl/note_lane_pingpong_buf_pp_bank_ram.sv | 27 ++
 rtl/note_lane_pingpong_buf.sv | 169 ++++++++++++++++
 tb/tb_note_lane_pingpong_buf.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/note_lane_pingpong_buf_pkg.sv
// rtl/note_lane_pingpong_buf_pkg.sv - shared state type and width helpers for the note-lane ping-pong buffer
package note_buf_pkg;

   typedef enum logic [1:0] {
      ST_INIT,
      ST_CLEAR,
      ST_FILL,
      ST_DONE
   } buf_state_t;

   // A single lane still needs one index bit so port widths never collapse to zero.
   function automatic int lane_w(input int lanes);
      return (lanes > 1) ? $clog2(lanes) : 1;
   endfunction

   function automatic int addr_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/note_lane_pingpong_buf_pp_bank_ram.sv
// rtl/note_lane_pingpong_buf_pp_bank_ram.sv - simple dual-port RAM, one write port and one registered read port
module pp_bank_ram #(
   parameter int AW = 7,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   // Sized to the full {bank, lane, addr} index space; lane codes >= LANES are never written.
   logic [DW-1:0] mem [0:(1 << AW) - 1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/note_lane_pingpong_buf.sv
// rtl/note_lane_pingpong_buf.sv - double-buffered note-lane y store with commit-gated frame swaps
module note_lane_pingpong_buf
   import note_buf_pkg::*;
#(
   parameter int             LANES         = 4,
   parameter int             DEPTH         = 16,
   parameter int             Y_W           = 8,
   parameter logic [Y_W-1:0] CLEAR_VAL     = '0,
   parameter int             CLEAR_ON_SWAP = 0,
   localparam int            LANE_W        = lane_w(LANES),
   localparam int            ADDR_W        = addr_w(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              frame_tick,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [LANE_W-1:0] wr_lane,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [Y_W-1:0]    wr_data,
   input  logic              wr_commit,
   input  logic              rd_en,
   input  logic [LANE_W-1:0] rd_lane,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [Y_W-1:0]    rd_data,
   output logic              rd_valid,
   output logic              front_bank,
   output logic [7:0]        drop_count
);

   localparam int                AW        = 1 + LANE_W + ADDR_W;
   localparam logic [LANE_W:0]   LANE_LIM  = (LANE_W + 1)'(LANES);
   localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
   localparam bit                SWAP_CLR  = (CLEAR_ON_SWAP != 0);

   buf_state_t        state;
   logic              sweep_bank;
   logic [LANE_W-1:0] sweep_lane;
   logic [ADDR_W-1:0] sweep_addr;
   logic              sweeping;
   logic              sweep_last;
   logic              wr_in_range;
   logic              rd_in_range;
   logic              wr_fire;
   logic              commit;
   logic              tick_swap;
   logic              ram_we;
   logic [AW-1:0]     ram_waddr;
   logic [Y_W-1:0]    ram_wdata;
   logic [AW-1:0]     ram_raddr;
   logic [Y_W-1:0]    ram_rdata;
   logic              rd_force;

   assign sweeping    = (state == ST_INIT) || (state == ST_CLEAR);
   // INIT covers both banks, CLEAR only the back bank.
   assign sweep_last  = (sweep_lane == LANE_LAST) && (sweep_addr == ADDR_LAST)
                        && ((state == ST_CLEAR) || sweep_bank);
   assign wr_in_range = ({1'b0, wr_lane} < LANE_LIM);
   assign rd_in_range = ({1'b0, rd_lane} < LANE_LIM);
   assign wr_fire     = wr_valid && wr_ready;
   assign commit      = wr_ready && wr_commit;
   assign tick_swap   = frame_tick && ((state == ST_DONE) || commit);

   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = {~front_bank, wr_lane, wr_addr};
      ram_wdata = wr_data;
      if (sweeping) begin
         ram_we    = 1'b1;
         ram_waddr = {(state == ST_INIT) ? sweep_bank : ~front_bank, sweep_lane, sweep_addr};
         ram_wdata = CLEAR_VAL;
      end else if (wr_fire && wr_in_range) begin
         ram_we = 1'b1;
      end
   end

   assign ram_raddr = {front_bank, rd_lane, rd_addr};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_INIT;
         wr_ready   <= 1'b0;
         sweep_bank <= 1'b0;
         sweep_lane <= '0;
         sweep_addr <= '0;
         front_bank <= 1'b0;
         drop_count <= '0;
      end else begin
         if (frame_tick && !tick_swap && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
         end
         if (tick_swap) begin
            front_bank <= ~front_bank;
         end
         case (state)
            ST_INIT, ST_CLEAR: begin
               if (sweep_last) begin
                  state      <= ST_FILL;
                  wr_ready   <= 1'b1;
                  sweep_bank <= 1'b0;
                  sweep_lane <= '0;
                  sweep_addr <= '0;
               end else if (sweep_addr == ADDR_LAST) begin
                  sweep_addr <= '0;
                  if (sweep_lane == LANE_LAST) begin
                     sweep_lane <= '0;
                     sweep_bank <= ~sweep_bank;
                  end else begin
                     sweep_lane <= sweep_lane + 1'b1;
                  end
               end else begin
                  sweep_addr <= sweep_addr + 1'b1;
               end
            end
            ST_FILL: begin
               if (commit) begin
                  if (tick_swap) begin
                     state    <= SWAP_CLR ? ST_CLEAR : ST_FILL;
                     wr_ready <= !SWAP_CLR;
                  end else begin
                     state    <= ST_DONE;
                     wr_ready <= 1'b0;
                  end
               end
            end
            ST_DONE: begin
               if (frame_tick) begin
                  state    <= SWAP_CLR ? ST_CLEAR : ST_FILL;
                  wr_ready <= !SWAP_CLR;
               end
            end
            default: begin
               state    <= ST_INIT;
               wr_ready <= 1'b0;
            end
         endcase
      end
   end

   // Out-of-range lanes and reads during INIT bypass the RAM, whose contents are not yet defined.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_valid <= 1'b0;
         rd_force <= 1'b1;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) begin
            rd_force <= (state == ST_INIT) || !rd_in_range;
         end
      end
   end

   assign rd_data = rd_force ? CLEAR_VAL : ram_rdata;

   pp_bank_ram #(
      .AW (AW),
      .DW (Y_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .re    (rd_en),
      .raddr (ram_raddr),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_note_lane_pingpong_buf.sv
// tb/tb_note_lane_pingpong_buf.sv - scoreboard bench for the note-lane ping-pong buffer
module tb_note_lane_pingpong_buf;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   // dut0: default parameters; dut1: three lanes, clear-on-swap, CLEAR_VAL = 0xFF
   logic       ft0, wv0, wc0, re0, wr0, rv0, fb0;
   logic [1:0] wl0, rl0;
   logic [3:0] wa0, ra0;
   logic [7:0] wd0, rd0, dc0;
   logic       ft1, wv1, wc1, re1, wr1, rv1, fb1;
   logic [1:0] wl1, rl1;
   logic [3:0] wa1, ra1;
   logic [7:0] wd1, rd1, dc1;

   int errors = 0;
   int checks = 0;
   int n;
   logic [7:0] q0[$];
   logic [7:0] q1[$];
   logic pend0, pend1;

   note_lane_pingpong_buf u_dut0 (
      .clk(clk), .reset(reset), .frame_tick(ft0), .wr_valid(wv0), .wr_ready(wr0),
      .wr_lane(wl0), .wr_addr(wa0), .wr_data(wd0), .wr_commit(wc0), .rd_en(re0),
      .rd_lane(rl0), .rd_addr(ra0), .rd_data(rd0), .rd_valid(rv0),
      .front_bank(fb0), .drop_count(dc0)
   );

   note_lane_pingpong_buf #(
      .LANES(3), .DEPTH(16), .Y_W(8), .CLEAR_VAL(8'hFF), .CLEAR_ON_SWAP(1)
   ) u_dut1 (
      .clk(clk), .reset(reset), .frame_tick(ft1), .wr_valid(wv1), .wr_ready(wr1),
      .wr_lane(wl1), .wr_addr(wa1), .wr_data(wd1), .wr_commit(wc1), .rd_en(re1),
      .rd_lane(rl1), .rd_addr(ra1), .rd_data(rd1), .rd_valid(rv1),
      .front_bank(fb1), .drop_count(dc1)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         pend0 <= 1'b0;
         pend1 <= 1'b0;
      end else begin
         pend0 <= re0;
         pend1 <= re1;
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         check_eq("rd_valid0", rv0, pend0);
         if (rv0) begin
            if (q0.size() > 0) check_eq("rd_data0", rd0, q0.pop_front());
            else check_eq("rd_valid0_spurious", rv0, 0);
         end
         check_eq("rd_valid1", rv1, pend1);
         if (rv1) begin
            if (q1.size() > 0) check_eq("rd_data1", rd1, q1.pop_front());
            else check_eq("rd_valid1_spurious", rv1, 0);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic read0(input logic [1:0] l, input logic [3:0] a, input logic [7:0] e);
      re0 = 1'b1; rl0 = l; ra0 = a; q0.push_back(e);
      step();
      re0 = 1'b0;
   endtask

   task automatic read1(input logic [1:0] l, input logic [3:0] a, input logic [7:0] e);
      re1 = 1'b1; rl1 = l; ra1 = a; q1.push_back(e);
      step();
      re1 = 1'b0;
   endtask

   task automatic write0(input logic [1:0] l, input logic [3:0] a, input logic [7:0] d);
      wv0 = 1'b1; wl0 = l; wa0 = a; wd0 = d;
      step();
      wv0 = 1'b0;
   endtask

   task automatic write1(input logic [1:0] l, input logic [3:0] a, input logic [7:0] d);
      wv1 = 1'b1; wl1 = l; wa1 = a; wd1 = d;
      check_eq("wr_ready1_hs", wr1, 1);
      step();
      wv1 = 1'b0;
   endtask

   task automatic swap1();
      wc1 = 1'b1;
      step();
      wc1 = 1'b0;
      ft1 = 1'b1;
      step();
      ft1 = 1'b0;
   endtask

   task automatic wait_ready1(input string tag);
      n = 0;
      while (!wr1 && n < 400) begin
         step();
         n++;
      end
      check_eq(tag, n, 48);
   endtask

   initial begin
      reset = 1'b1;
      {ft0, wv0, wc0, re0, wl0, rl0, wa0, ra0, wd0} = '0;
      {ft1, wv1, wc1, re1, wl1, rl1, wa1, ra1, wd1} = '0;
      step();
      step();
      check_eq("rst_front0", fb0, 0);
      check_eq("rst_rd_data0", rd0, 8'h00);
      check_eq("rst_rd_valid0", rv0, 0);
      check_eq("rst_drop0", dc0, 0);
      check_eq("rst_ready0", wr0, 0);
      check_eq("rst_rd_data1", rd1, 8'hFF);
      check_eq("rst_ready1", wr1, 0);

      // release, read during INIT, count cycles to first wr_ready
      reset = 1'b0;
      re0 = 1'b1; rl0 = 2'd2; ra0 = 4'd5; q0.push_back(8'h00);
      step();
      re0 = 1'b0;
      n = 1;
      while (!wr0 && n < 400) begin
         step();
         n++;
      end
      check_eq("init_cycles0", n, 128);
      for (int i = 0; i < 4; i++) read0(2'($urandom_range(3)), 4'($urandom_range(15)), 8'h00);

      // fill and swap
      write0(2'd2, 4'd5, 8'h3C);
      check_eq("ready_fill0", wr0, 1);
      wc0 = 1'b1;
      step();
      wc0 = 1'b0;
      check_eq("ready_done0", wr0, 0);
      ft0 = 1'b1; re0 = 1'b1; rl0 = 2'd2; ra0 = 4'd5; q0.push_back(8'h00);
      step();
      ft0 = 1'b0;
      check_eq("swap_front0", fb0, 1);
      check_eq("swap_ready0", wr0, 1);
      q0.push_back(8'h3C);
      step();
      re0 = 1'b0;

      // dropped frames, then write + commit + tick in one cycle
      repeat (3) begin
         ft0 = 1'b1; step(); ft0 = 1'b0; step();
      end
      check_eq("drop3", dc0, 3);
      check_eq("drop_front0", fb0, 1);
      wv0 = 1'b1; wl0 = 2'd1; wa0 = 4'd7; wd0 = 8'h5A; wc0 = 1'b1; ft0 = 1'b1;
      step();
      {wv0, wc0, ft0} = '0;
      check_eq("same_cyc_front0", fb0, 0);
      check_eq("same_cyc_drop0", dc0, 3);
      check_eq("same_cyc_ready0", wr0, 1);
      read0(2'd1, 4'd7, 8'h5A);
      read0(2'd2, 4'd5, 8'h00);

      // saturation
      repeat (300) begin
         ft0 = 1'b1; step(); ft0 = 1'b0; step();
      end
      check_eq("drop_sat", dc0, 8'hFF);
      check_eq("sat_front0", fb0, 0);

      // writes ignored while DONE
      wc0 = 1'b1;
      step();
      wc0 = 1'b0;
      write0(2'd0, 4'd0, 8'h77);
      check_eq("done_ready0", wr0, 0);
      ft0 = 1'b1;
      step();
      ft0 = 1'b0;
      check_eq("swap2_front0", fb0, 1);
      check_eq("swap2_drop0", dc0, 8'hFF);
      read0(2'd0, 4'd0, 8'h00);
      read0(2'd2, 4'd5, 8'h3C);

      // async reset mid-fill with a read in flight
      write0(2'd3, 4'd3, 8'h99);
      read0(2'd3, 4'd3, 8'h00);
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      check_eq("arst_front0", fb0, 0);
      check_eq("arst_rd_valid0", rv0, 0);
      check_eq("arst_rd_data0", rd0, 8'h00);
      check_eq("arst_ready0", wr0, 0);
      check_eq("arst_drop0", dc0, 0);
      step();
      reset = 1'b0;
      n = 0;
      while (!wr0 && n < 400) begin
         step();
         n++;
      end
      check_eq("reinit_cycles0", n, 128);
      read0(2'd1, 4'd7, 8'h00);

      // clear-on-swap instance, out-of-range lane
      read1(2'd0, 4'd0, 8'hFF);
      write1(2'd0, 4'd3, 8'h11);
      write1(2'd3, 4'd3, 8'h22);
      write1(2'd2, 4'd15, 8'h33);
      swap1();
      check_eq("swap_front1", fb1, 1);
      check_eq("clear_ready1", wr1, 0);
      wait_ready1("clear_cycles1_a");
      read1(2'd0, 4'd3, 8'h11);
      read1(2'd2, 4'd15, 8'h33);
      read1(2'd0, 4'd4, 8'hFF);
      read1(2'd3, 4'd3, 8'hFF);
      check_eq("drop1", dc1, 0);
      swap1();
      check_eq("swap2_front1", fb1, 0);
      wait_ready1("clear_cycles1_b");
      swap1();
      check_eq("swap3_front1", fb1, 1);
      wait_ready1("clear_cycles1_c");
      read1(2'd0, 4'd3, 8'hFF);
      read1(2'd2, 4'd15, 8'hFF);

      repeat (3) step();
      check_eq("drain0", q0.size(), 0);
      check_eq("drain1", q1.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
